// File: rtl/rl_ras_ecc_agg.sv
// rl_ras_ecc_agg: parametrised N-channel RAS ECC error aggregator.
// Collects per-channel SBE/DBE/ADR strobes and keeps the following state:
//   - saturating SBE counters with a programmable overflow threshold
//   - a sticky status word
//   - a first-error capture log for each channel
// All of this state is exposed through a simple register port and also drives
// the sfty_mem_* / high_prio_ras safety outputs.
//
// Optional macro: RAS_ERR_INJECT_EN adds a write-only INJECT register (0x08)
// that fires a one-cycle error strobe into a selected channel.
//
// Ports:
//   clk, rst_a (async, active-low)
//   ch_sb_err / ch_db_err / ch_addr_err [NUM_CH] : per-channel error strobes
//   ch_syndrome [NUM_CH*SYND_W], ch_addr [NUM_CH*ADDR_W] : per-channel error data
//   reg_ren, reg_wen, reg_addr[7:0], reg_wdata[31:0] : register access
//   reg_rdata[31:0], reg_rvalid : registered read response
//   sfty_mem_sbe_err, sfty_mem_dbe_err, sfty_mem_adr_err, sfty_mem_sbe_overflow,
//   high_prio_ras : registered ORs of the sticky bits
module rl_ras_ecc_agg #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned SYND_W = 8,
   parameter int unsigned ADDR_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_a,
   input  logic [NUM_CH-1:0]          ch_sb_err,
   input  logic [NUM_CH-1:0]          ch_db_err,
   input  logic [NUM_CH-1:0]          ch_addr_err,
   input  logic [NUM_CH*SYND_W-1:0]   ch_syndrome,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic                       reg_ren,
   input  logic                       reg_wen,
   input  logic [7:0]                 reg_addr,
   input  logic [31:0]                reg_wdata,
   output logic [31:0]                reg_rdata,
   output logic                       reg_rvalid,
   output logic                       sfty_mem_sbe_err,
   output logic                       sfty_mem_dbe_err,
   output logic                       sfty_mem_adr_err,
   output logic                       sfty_mem_sbe_overflow,
   output logic                       high_prio_ras
);

   localparam logic [1:0]       TYPE_SB  = 2'b01;
   localparam logic [1:0]       TYPE_DB  = 2'b10;
   localparam logic [1:0]       TYPE_ADR = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [5:0]       W_STATUS = 6'd0;
   localparam logic [5:0]       W_THRESH = 6'd1;

   logic [5:0] word_c;
   assign word_c = reg_addr[7:2];

   // Byte-lane bits of the address and unused write-data bits are don't-care.
   logic unused_c;
   assign unused_c = ^{reg_addr[1:0], reg_wdata};

   // Effective per-channel event strobes and capture data
   logic [NUM_CH-1:0] sb_c, db_c, adr_c;
   logic [SYND_W-1:0] synd_c  [NUM_CH];
   logic [ADDR_W-1:0] eaddr_c [NUM_CH];

`ifdef RAS_ERR_INJECT_EN
   localparam logic [5:0] W_INJECT = 6'd2;

   logic [NUM_CH-1:0] inj_sb_q, inj_db_q, inj_adr_q;
   logic [NUM_CH-1:0] inj_sb_d, inj_db_d, inj_adr_d;

   // INJECT write decode; a channel select beyond NUM_CH matches nothing
   always_comb begin
      inj_sb_d  = '0;
      inj_db_d  = '0;
      inj_adr_d = '0;
      if (reg_wen && (word_c == W_INJECT)) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (reg_wdata[2:0] == 3'(c)) begin
               inj_sb_d[c]  = (reg_wdata[5:4] == TYPE_SB);
               inj_db_d[c]  = (reg_wdata[5:4] == TYPE_DB);
               inj_adr_d[c] = (reg_wdata[5:4] == TYPE_ADR);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         inj_sb_q  <= '0;
         inj_db_q  <= '0;
         inj_adr_q <= '0;
      end else begin
         inj_sb_q  <= inj_sb_d;
         inj_db_q  <= inj_db_d;
         inj_adr_q <= inj_adr_d;
      end
   end

   // Injected events carry an all-ones syndrome and address 0
   always_comb begin
      sb_c  = ch_sb_err   | inj_sb_q;
      db_c  = ch_db_err   | inj_db_q;
      adr_c = ch_addr_err | inj_adr_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (inj_sb_q[c] || inj_db_q[c] || inj_adr_q[c]) begin
            synd_c[c]  = '1;
            eaddr_c[c] = '0;
         end else begin
            synd_c[c]  = ch_syndrome[c*SYND_W +: SYND_W];
            eaddr_c[c] = ch_addr[c*ADDR_W +: ADDR_W];
         end
      end
   end
`else
   always_comb begin
      sb_c  = ch_sb_err;
      db_c  = ch_db_err;
      adr_c = ch_addr_err;
      for (int c = 0; c < NUM_CH; c++) begin
         synd_c[c]  = ch_syndrome[c*SYND_W +: SYND_W];
         eaddr_c[c] = ch_addr[c*ADDR_W +: ADDR_W];
      end
   end
`endif

   // Architectural state
   logic [NUM_CH-1:0] sbe_q, sbe_d, dbe_q, dbe_d, adr_q, adr_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]  thresh_q, thresh_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] log_vld_q, log_vld_d;
   logic [1:0]        log_type_q [NUM_CH];
   logic [1:0]        log_type_d [NUM_CH];
   logic [SYND_W-1:0] log_synd_q [NUM_CH];
   logic [SYND_W-1:0] log_synd_d [NUM_CH];
   logic [ADDR_W-1:0] log_addr_q [NUM_CH];
   logic [ADDR_W-1:0] log_addr_d [NUM_CH];

   // Register-port and safety-output flops
   logic [31:0] rdata_q, rdata_d, rd_c;
   logic        rvalid_q, rvalid_d;
   logic        sbe_any_q, sbe_any_d, dbe_any_q, dbe_any_d;
   logic        adr_any_q, adr_any_d, ovf_any_q, ovf_any_d;
   logic        hprio_q, hprio_d;

   // Next state: stickies, threshold, counters, logs
   always_comb begin : next_state
      logic [CNT_W-1:0] cnt_base;
      logic [1:0]       ev_type;

      thresh_d = thresh_q;
      sbe_d    = sbe_q;
      dbe_d    = dbe_q;
      adr_d    = adr_q;
      ovf_d    = ovf_q;
      cnt_base = '0;
      ev_type  = 2'b00;

      if (reg_wen && (word_c == W_THRESH)) thresh_d = reg_wdata[CNT_W-1:0];

      // W1C is applied first so that a same-cycle event leaves the bit set
      if (reg_wen && (word_c == W_STATUS)) begin
         sbe_d = sbe_q & ~reg_wdata[0  +: NUM_CH];
         dbe_d = dbe_q & ~reg_wdata[8  +: NUM_CH];
         adr_d = adr_q & ~reg_wdata[16 +: NUM_CH];
         ovf_d = ovf_q & ~reg_wdata[24 +: NUM_CH];
      end
      sbe_d = sbe_d | sb_c;
      dbe_d = dbe_d | db_c;
      adr_d = adr_d | adr_c;

      for (int c = 0; c < NUM_CH; c++) begin
         // A clear and an increment in the same cycle leave the counter at 1
         cnt_base = (reg_wen && (word_c == 6'(4 + c))) ? '0 : cnt_q[c];
         cnt_d[c] = cnt_base;
         if (sb_c[c]) begin
            if (cnt_base != CNT_MAX) cnt_d[c] = cnt_base + CNT_W'(1);
            // Overflow is evaluated on each SBE event against the new count
            if ((thresh_q != '0) && (cnt_d[c] >= thresh_q)) ovf_d[c] = 1'b1;
         end

         log_vld_d[c]  = log_vld_q[c];
         log_type_d[c] = log_type_q[c];
         log_synd_d[c] = log_synd_q[c];
         log_addr_d[c] = log_addr_q[c];
         if (reg_wen && (word_c == 6'(16 + 2*c)) && reg_wdata[31]) log_vld_d[c] = 1'b0;

         ev_type = adr_c[c] ? TYPE_ADR :
                   db_c[c]  ? TYPE_DB  :
                   sb_c[c]  ? TYPE_SB  : 2'b00;
         // Capture into an empty log, or upgrade a held SB entry to DB/ADR
         if ((ev_type != 2'b00) &&
             (!log_vld_q[c] || ((log_type_q[c] == TYPE_SB) && (ev_type != TYPE_SB)))) begin
            log_vld_d[c]  = 1'b1;
            log_type_d[c] = ev_type;
            log_synd_d[c] = synd_c[c];
            log_addr_d[c] = eaddr_c[c];
         end
      end
   end

   // Read mux over the current (pre-write) state
   always_comb begin
      rd_c = '0;
      case (word_c)
         W_STATUS: begin
            rd_c[0  +: NUM_CH] = sbe_q;
            rd_c[8  +: NUM_CH] = dbe_q;
            rd_c[16 +: NUM_CH] = adr_q;
            rd_c[24 +: NUM_CH] = ovf_q;
         end
         W_THRESH: rd_c = 32'(thresh_q);
         default:  rd_c = '0;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (word_c == 6'(4 + c))      rd_c = 32'(cnt_q[c]);
         if (word_c == 6'(16 + 2*c))   rd_c = {log_vld_q[c], log_type_q[c], 29'd0} |
                                              32'(log_synd_q[c]);
         if (word_c == 6'(17 + 2*c))   rd_c = 32'(log_addr_q[c]);
      end
   end

   // Read response and safety outputs
   always_comb begin
      rvalid_d  = reg_ren;
      rdata_d   = reg_ren ? rd_c : rdata_q;
      sbe_any_d = |sbe_q;
      dbe_any_d = |dbe_q;
      adr_any_d = |adr_q;
      ovf_any_d = |ovf_q;
      hprio_d   = (|dbe_q) | (|adr_q);
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         sbe_q     <= '0;
         dbe_q     <= '0;
         adr_q     <= '0;
         ovf_q     <= '0;
         thresh_q  <= '0;
         log_vld_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]      <= '0;
            log_type_q[c] <= '0;
            log_synd_q[c] <= '0;
            log_addr_q[c] <= '0;
         end
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         sbe_any_q <= 1'b0;
         dbe_any_q <= 1'b0;
         adr_any_q <= 1'b0;
         ovf_any_q <= 1'b0;
         hprio_q   <= 1'b0;
      end else begin
         sbe_q     <= sbe_d;
         dbe_q     <= dbe_d;
         adr_q     <= adr_d;
         ovf_q     <= ovf_d;
         thresh_q  <= thresh_d;
         log_vld_q <= log_vld_d;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]      <= cnt_d[c];
            log_type_q[c] <= log_type_d[c];
            log_synd_q[c] <= log_synd_d[c];
            log_addr_q[c] <= log_addr_d[c];
         end
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         sbe_any_q <= sbe_any_d;
         dbe_any_q <= dbe_any_d;
         adr_any_q <= adr_any_d;
         ovf_any_q <= ovf_any_d;
         hprio_q   <= hprio_d;
      end
   end

   assign reg_rdata             = rdata_q;
   assign reg_rvalid            = rvalid_q;
   assign sfty_mem_sbe_err      = sbe_any_q;
   assign sfty_mem_dbe_err      = dbe_any_q;
   assign sfty_mem_adr_err      = adr_any_q;
   assign sfty_mem_sbe_overflow = ovf_any_q;
   assign high_prio_ras         = hprio_q;

endmodule

// File: tb/tb_rl_ras_ecc_agg.sv
// Testbench for rl_ras_ecc_agg. A behavioural model steps on each clock edge.
// One compare process checks every DUT output against that model on each
// falling edge. Directed sequences pin the model with literal expectations.
// Randomised traffic then exercises the design against the model.
module tb_rl_ras_ecc_agg;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned SYND_W = 8;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned SW     = NUM_CH*SYND_W;
   localparam int unsigned AW     = NUM_CH*ADDR_W;
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_a;
   logic [NUM_CH-1:0] ch_sb_err, ch_db_err, ch_addr_err;
   logic [SW-1:0]     ch_syndrome;
   logic [AW-1:0]     ch_addr;
   logic              reg_ren, reg_wen;
   logic [7:0]        reg_addr;
   logic [31:0]       reg_wdata;
   logic [31:0]       reg_rdata;
   logic              reg_rvalid;
   logic              sfty_mem_sbe_err, sfty_mem_dbe_err, sfty_mem_adr_err;
   logic              sfty_mem_sbe_overflow, high_prio_ras;

   always #5 clk = ~clk;

   rl_ras_ecc_agg #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYND_W(SYND_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_a(rst_a),
      .ch_sb_err(ch_sb_err), .ch_db_err(ch_db_err), .ch_addr_err(ch_addr_err),
      .ch_syndrome(ch_syndrome), .ch_addr(ch_addr),
      .reg_ren(reg_ren), .reg_wen(reg_wen), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
      .sfty_mem_sbe_err(sfty_mem_sbe_err), .sfty_mem_dbe_err(sfty_mem_dbe_err),
      .sfty_mem_adr_err(sfty_mem_adr_err), .sfty_mem_sbe_overflow(sfty_mem_sbe_overflow),
      .high_prio_ras(high_prio_ras)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_sbe [NUM_CH], m_dbe [NUM_CH], m_adr [NUM_CH], m_ovf [NUM_CH];
   int          m_cnt [NUM_CH];
   int          m_thresh;
   bit          m_lv  [NUM_CH];
   int          m_lt  [NUM_CH];
   logic [31:0] m_ls  [NUM_CH], m_la [NUM_CH];
   int          m_inj [NUM_CH];
   logic [31:0] e_rdata;
   bit          e_rvalid, e_sbe, e_dbe, e_adr, e_ovf, e_hp;

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      int          a, c;
      logic [31:0] r;
      r = '0;
      a = int'(addr & 8'hFC);
      if (a == 0) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r[i] = m_sbe[i]; r[8+i] = m_dbe[i]; r[16+i] = m_adr[i]; r[24+i] = m_ovf[i];
         end
      end else if (a == 4) begin
         r = 32'(m_thresh);
      end else if (a >= 16 && a < 48) begin
         c = (a - 16) / 4;
         if (c < NUM_CH) r = 32'(m_cnt[c]);
      end else if (a >= 64 && a < 128) begin
         c = (a - 64) / 8;
         if (c < NUM_CH) begin
            if (((a - 64) % 8) == 0) r = {m_lv[c], 2'(m_lt[c]), 29'd0} | m_ls[c];
            else                     r = m_la[c];
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_sbe[c] = 0; m_dbe[c] = 0; m_adr[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
         m_lv[c] = 0; m_lt[c] = 0; m_ls[c] = '0; m_la[c] = '0; m_inj[c] = 0;
      end
      m_thresh = 0;
      e_rdata = '0; e_rvalid = 0; e_sbe = 0; e_dbe = 0; e_adr = 0; e_ovf = 0; e_hp = 0;
   endtask

   task automatic model_step();
      int          a, t, old_t, new_thresh;
      bit          sb, db, ad, old_v;
      logic [31:0] syn, adr;
      int          nxt_inj [NUM_CH];
      e_sbe = 0; e_dbe = 0; e_adr = 0; e_ovf = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         e_sbe |= m_sbe[c]; e_dbe |= m_dbe[c]; e_adr |= m_adr[c]; e_ovf |= m_ovf[c];
      end
      e_hp = e_dbe | e_adr;
      e_rvalid = reg_ren;
      if (reg_ren) e_rdata = model_read(reg_addr);
      a = int'(reg_addr & 8'hFC);
      new_thresh = m_thresh;
      if (reg_wen && a == 4) new_thresh = int'(reg_wdata) & CMAX;
      for (int c = 0; c < NUM_CH; c++) nxt_inj[c] = 0;
`ifdef RAS_ERR_INJECT_EN
      if (reg_wen && a == 8 && reg_wdata[2:0] < NUM_CH && reg_wdata[5:4] != 2'b00)
         nxt_inj[reg_wdata[2:0]] = int'(reg_wdata[5:4]);
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         sb = ch_sb_err[c]   || m_inj[c] == 1;
         db = ch_db_err[c]   || m_inj[c] == 2;
         ad = ch_addr_err[c] || m_inj[c] == 3;
         syn = '0; adr = '0;
         if (m_inj[c] != 0) syn[SYND_W-1:0] = '1;
         else begin
            syn[SYND_W-1:0] = ch_syndrome[c*SYND_W +: SYND_W];
            adr[ADDR_W-1:0] = ch_addr[c*ADDR_W +: ADDR_W];
         end
         if (reg_wen && a == 0) begin
            if (reg_wdata[c])    m_sbe[c] = 0;
            if (reg_wdata[8+c])  m_dbe[c] = 0;
            if (reg_wdata[16+c]) m_adr[c] = 0;
            if (reg_wdata[24+c]) m_ovf[c] = 0;
         end
         if (sb) m_sbe[c] = 1;
         if (db) m_dbe[c] = 1;
         if (ad) m_adr[c] = 1;
         if (reg_wen && a == 16 + 4*c) m_cnt[c] = 0;
         if (sb) begin
            m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
            if (m_thresh != 0 && m_cnt[c] >= m_thresh) m_ovf[c] = 1;
         end
         t = ad ? 3 : db ? 2 : sb ? 1 : 0;
         old_v = m_lv[c]; old_t = m_lt[c];
         if (reg_wen && a == 64 + 8*c && reg_wdata[31]) m_lv[c] = 0;
         if (t != 0 && (!old_v || (old_t == 1 && t > 1))) begin
            m_lv[c] = 1; m_lt[c] = t; m_ls[c] = syn; m_la[c] = adr;
         end
      end
      m_inj = nxt_inj;
      m_thresh = new_thresh;
   endtask

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) model_reset();
      else        model_step();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && rst_a) begin
         chk("cmp_rvalid",   32'(reg_rvalid),            32'(e_rvalid));
         chk("cmp_rdata",    reg_rdata,                  e_rdata);
         chk("cmp_sbe_err",  32'(sfty_mem_sbe_err),      32'(e_sbe));
         chk("cmp_dbe_err",  32'(sfty_mem_dbe_err),      32'(e_dbe));
         chk("cmp_adr_err",  32'(sfty_mem_adr_err),      32'(e_adr));
         chk("cmp_overflow", 32'(sfty_mem_sbe_overflow), 32'(e_ovf));
         chk("cmp_hprio",    32'(high_prio_ras),         32'(e_hp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_in();
      ch_sb_err = '0; ch_db_err = '0; ch_addr_err = '0;
      reg_ren = 1'b0; reg_wen = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      idle_in();
   endtask

   task automatic chk_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
      reg_ren = 1'b1; reg_addr = a;
      @(negedge clk);
      idle_in();
      chk(name, reg_rdata, exp);
      chk({name, "_rvalid"}, 32'(reg_rvalid), 32'd1);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_rvalid"},   32'(reg_rvalid), 32'd0);
      chk({name, "_rdata"},    reg_rdata, 32'd0);
      chk({name, "_outs"},     32'({sfty_mem_sbe_err, sfty_mem_dbe_err, sfty_mem_adr_err,
                                    sfty_mem_sbe_overflow, high_prio_ras}), 32'd0);
   endtask

   logic [7:0] ra;
   int         op, sel;

   initial begin
      rst_a = 1'b0;
      idle_in();
      reg_addr = '0; reg_wdata = '0; ch_syndrome = '0; ch_addr = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_hold");
      rst_a = 1'b1;
      chk_en = 1'b1;

      // Every register reads 0 after reset
      for (int a = 0; a < 128; a += 4) chk_rd(8'(a), 32'd0, "reset_read");
      @(negedge clk);
      chk("rvalid_pulse", 32'(reg_rvalid), 32'd0);

      // Overflow at threshold 3 on channel 1
      wr(8'h04, 32'd3);
      repeat (3) begin ch_sb_err[1] = 1'b1; @(negedge clk); idle_in(); end
      chk_rd(8'h14, 32'd3, "cnt1");
      chk_rd(8'h00, 32'h0200_0002, "status_ovf");
      chk("ovf_out", 32'(sfty_mem_sbe_overflow), 32'd1);
      chk("hprio_sb_only", 32'(high_prio_ras), 32'd0);

      // Saturation with overflow detection disabled
      wr(8'h04, 32'd0);
      ch_sb_err[0] = 1'b1;
      repeat (300) @(negedge clk);
      idle_in();
      chk_rd(8'h10, 32'd255, "cnt0_sat");
      chk_rd(8'h00, 32'h0200_0003, "status_no_ovf0");

      // Log capture, DB upgrade over SB, then SB does not overwrite
      ch_syndrome[2*SYND_W +: SYND_W] = SYND_W'(8'h11);
      ch_addr[2*ADDR_W +: ADDR_W]     = ADDR_W'(16'h0100);
      ch_sb_err[2] = 1'b1; @(negedge clk); idle_in();
      ch_syndrome[2*SYND_W +: SYND_W] = SYND_W'(8'h22);
      ch_addr[2*ADDR_W +: ADDR_W]     = ADDR_W'(16'h0200);
      ch_db_err[2] = 1'b1; @(negedge clk); idle_in();
      ch_syndrome[2*SYND_W +: SYND_W] = SYND_W'(8'h33);
      ch_addr[2*ADDR_W +: ADDR_W]     = ADDR_W'(16'h0300);
      ch_sb_err[2] = 1'b1; @(negedge clk); idle_in();
      // Clear and increment in one cycle
      ch_sb_err[2] = 1'b1; wr(8'h18, 32'd0);
      chk_rd(8'h18, 32'd1, "cnt2_clr_inc");
      chk_rd(8'h50, 32'hC000_0022, "log0_2");
      chk_rd(8'h54, 32'h0000_0200, "log1_2");
      chk("hprio_db", 32'(high_prio_ras), 32'd1);

      // W1C racing a new DB event keeps the bit; a later W1C clears it
      ch_db_err[1] = 1'b1; @(negedge clk); idle_in();
      ch_db_err[1] = 1'b1; wr(8'h00, 32'h0000_0200);
      chk_rd(8'h00, 32'h0200_0607, "status_w1c_race");
      wr(8'h00, 32'h0000_0600);
      chk("dbe_out_lag", 32'(sfty_mem_dbe_err), 32'd1);
      @(negedge clk);
      chk("dbe_out_drop", 32'(sfty_mem_dbe_err), 32'd0);
      chk("hprio_drop", 32'(high_prio_ras), 32'd0);
      chk_rd(8'h00, 32'h0200_0007, "status_w1c_done");

`ifdef RAS_ERR_INJECT_EN
      // ADR injection on channel 3
      wr(8'h08, 32'h0000_0033);
      @(negedge clk);
      chk_rd(8'h00, 32'h0208_0007, "inj_status");
      chk_rd(8'h58, 32'hE000_00FF, "inj_log0_3");
      chk_rd(8'h08, 32'd0, "inj_reads0");
`endif

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ch_sb_err[c]   = ($urandom_range(0, 3)  == 0);
            ch_db_err[c]   = ($urandom_range(0, 15) == 0);
            ch_addr_err[c] = ($urandom_range(0, 31) == 0);
         end
         ch_syndrome = SW'($urandom);
         ch_addr     = AW'({$urandom, $urandom});
         sel = $urandom_range(0, 5);
         case (sel)
            0:       ra = 8'h00;
            1:       ra = 8'h04;
            2:       ra = 8'h08;
            3:       ra = 8'(16 + 4*$urandom_range(0, 7));
            4:       ra = 8'(64 + 4*$urandom_range(0, 15));
            default: ra = 8'($urandom);
         endcase
         ra = ra | 8'($urandom_range(0, 3));
         reg_addr  = ra;
         reg_wdata = (sel == 1) ? 32'($urandom_range(0, 12)) : $urandom;
         op = $urandom_range(0, 7);
         reg_ren = (op <= 1) || (op == 3);
         reg_wen = (op == 2) || (op == 3);
         @(negedge clk);
      end
      idle_in();
      repeat (3) @(negedge clk);

      // Reset in the middle of a read
      reg_ren = 1'b1; reg_addr = 8'h00;
      @(posedge clk);
      #2 rst_a = 1'b0;
      #1 check_all_zero("reset_mid");
      idle_in();
      @(negedge clk);
      rst_a = 1'b1;
      chk_rd(8'h00, 32'd0, "post_reset_status");
      chk_rd(8'h10, 32'd0, "post_reset_cnt0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
